seq_chunk_adder: RTL and testbench

Multi-cycle, parametrised add/subtract unit. It processes a WIDTH-bit operation CHUNK bits per clock, using a registered carry between chunks. Width scales without a long combinational carry chain, and the result comes with carry and signed-overflow flags. It sits beside the combinational adders as the area-lean datapath option, driven by a start/done handshake from a controller.

---
 rtl/seq_chunk_adder.sv | 112 +++++++++++
 tb/tb_seq_chunk_adder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/subtract unit. A WIDTH-bit operation is
// processed CHUNK bits per clock through a registered carry. The result and
// its carry / signed-overflow flags are published together on completion.
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;    // remaining operand A chunks, current chunk in the low bits
  logic [WIDTH-1:0] op_b;    // remaining operand B chunks (already inverted for sub)
  logic [WIDTH-1:0] acc;     // partial result, filled from the top as chunks complete
  logic             carry;   // carry between chunks
  logic [KW-1:0]    k;       // chunk index

  logic [CHUNK:0]   chunk_full;
  logic [WIDTH-1:0] chunk_ext;
  logic [WIDTH-1:0] acc_next;
  logic             msb_cin;
  logic             last;

  // Chunk adder for the current step plus the accumulator it produces.
  // NOTE: every always_comb output gets a default before any conditional
  // logic, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    chunk_full = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]} + (CHUNK+1)'(carry);
    chunk_ext  = '0;
    chunk_ext[CHUNK-1:0] = chunk_full[CHUNK-1:0];
    // Shift completed chunks down; after NCH steps chunk 0 sits at bit 0.
    acc_next   = (acc >> CHUNK) | (chunk_ext << (WIDTH - CHUNK));
    // Carry into a bit equals a ^ b ^ sum of that bit; only meaningful on the
    // last chunk, where bit CHUNK-1 of the chunk is the operand MSB.
    msb_cin    = op_a[CHUNK-1] ^ op_b[CHUNK-1] ^ chunk_full[CHUNK-1];
    last       = (k == KW'(NCH - 1));
  end

  // Control FSM, chunk datapath and registered outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      k     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            acc   <= '0;
            k     <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          carry <= chunk_full[CHUNK];
          op_a  <= op_a >> CHUNK;
          op_b  <= op_b >> CHUNK;
          k     <= k + KW'(1);
          if (last) begin
            sum   <= acc_next;
            cout  <= chunk_full[CHUNK];
            ovf   <= msb_cin ^ chunk_full[CHUNK];
            done  <= 1'b1;
            busy  <= 1'b0;
            k     <= '0;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: a 32/8 instance and an 8/8 instance, checked
// against an arithmetic reference model with directed and random operations.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit, 8-bit chunk instance
  logic        start32 = 1'b0, sub32 = 1'b0, cin32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, cout32, ovf32;
  logic [31:0] sum32;

  // 8-bit, single chunk instance
  logic        start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .sub(sub32), .a(a32), .b(b32), .cin(cin32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  // Observed outputs of whichever instance is under test.
  bit          sel8 = 1'b0;
  logic        o_busy, o_done, o_cout, o_ovf;
  logic [31:0] o_sum;
  assign o_busy = sel8 ? busy8 : busy32;
  assign o_done = sel8 ? done8 : done32;
  assign o_cout = sel8 ? cout8 : cout32;
  assign o_ovf  = sel8 ? ovf8  : ovf32;
  assign o_sum  = sel8 ? {24'd0, sum8} : sum32;

  int total = 0;
  int bad   = 0;

  // Last completed result per instance: {ovf, cout, sum}.
  logic [33:0] held [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic on the full width.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic sb, input logic ci);
    logic [63:0] mask, aa, bb, full, s;
    logic        co, ov, am, bm, sm;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = {32'd0, (sb ? ~b : b)} & mask;
    full = aa + bb + ((sb || ci) ? 64'd1 : 64'd0);
    s    = full & mask;
    co   = full[w];
    am   = aa[w-1];
    bm   = bb[w-1];
    sm   = s[w-1];
    ov   = (am == bm) && (sm != am);
    return {ov, co, s[31:0]};
  endfunction

  // Issue one operation from a negedge; returns at the negedge where done is seen.
  task automatic op(input bit s8, input logic [31:0] a, input logic [31:0] b,
                    input logic sb, input logic ci, input bit disturb);
    logic [33:0] exp;
    int nch, cyc, busy_cnt;
    sel8 = s8;
    nch  = s8 ? 1 : 4;
    exp  = model(s8 ? 8 : 32, a, b, sb, ci);
    if (s8) begin
      a8 = a[7:0]; b8 = b[7:0]; sub8 = sb; cin8 = ci; start8 = 1'b1;
    end else begin
      a32 = a; b32 = b; sub32 = sb; cin32 = ci; start32 = 1'b1;
    end
    @(negedge clk);
    start8 = 1'b0;
    start32 = 1'b0;
    cyc = 0;
    busy_cnt = 0;
    while (!o_done && cyc < 50) begin
      if (o_busy) busy_cnt++;
      check("hold", {30'd0, o_ovf, o_cout, o_sum}, {30'd0, held[s8]});
      if (disturb && !s8 && cyc == 1) begin
        start32 = 1'b1; a32 = $urandom; b32 = $urandom;
        sub32 = 1'($urandom); cin32 = 1'($urandom);
      end
      if (disturb && !s8 && cyc == 2) begin
        start32 = 1'b0; a32 = ~a32; b32 = ~b32;
      end
      @(negedge clk);
      cyc++;
    end
    start32 = 1'b0;
    check("latency", 64'(cyc), 64'(nch));
    check("busy_cycles", 64'(busy_cnt), 64'(nch));
    check("sum", {32'd0, o_sum}, {32'd0, exp[31:0]});
    check("cout", {63'd0, o_cout}, {63'd0, exp[32]});
    check("ovf", {63'd0, o_ovf}, {63'd0, exp[33]});
    held[s8] = exp;
  endtask

  // One cycle after a done: the pulse must have fallen and the unit be idle.
  task automatic settle();
    @(negedge clk);
    check("done_pulse", {63'd0, o_done}, 64'd0);
    check("idle_busy", {63'd0, o_busy}, 64'd0);
  endtask

  initial begin
    held[0] = '0;
    held[1] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy32", {63'd0, busy32}, 64'd0);
    check("rst_done32", {63'd0, done32}, 64'd0);
    check("rst_res32", {30'd0, ovf32, cout32, sum32}, 64'd0);
    check("rst_res8", {54'd0, busy8, done8, ovf8, cout8, sum8}, 64'd0);
    rst = 1'b0;

    // Directed: carry ripple through every chunk, subtract, signed overflow.
    op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0); settle();
    op(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0); settle();
    op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0); settle();
    op(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0); settle();

    // Start and operand changes during RUN must be ignored.
    op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1); settle();

    // Reset on the second RUN cycle aborts the operation.
    a32 = 32'hDEAD_BEEF; b32 = 32'h0101_0101; sub32 = 1'b0; cin32 = 1'b0; start32 = 1'b1;
    sel8 = 1'b0;
    @(negedge clk);
    start32 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {63'd0, busy32}, 64'd0);
    check("abort_done", {63'd0, done32}, 64'd0);
    check("abort_res", {30'd0, ovf32, cout32, sum32}, 64'd0);
    held[0] = '0;
    held[1] = '0;
    rst = 1'b0;
    op(0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0); settle();

    // Single-chunk instance, then a back-to-back start in the DONE cycle.
    op(1, 32'h7F, 32'h00, 1'b0, 1'b1, 1'b0);
    op(1, 32'h10, 32'h20, 1'b1, 1'b0, 1'b0); settle();

    // Random operations on both instances, sometimes chained back-to-back.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 12; i++) begin
        bit b2b;
        b2b = 1'($urandom);
        op(s[0], $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
        if (!b2b) settle();
      end
      settle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
